run_launcher: RTL and testbench

- Host-side initiator for the processor's start/ack run handshake.
- On a host request it latches a program select and drives `start` high for a fixed number of cycles, then drops it.
- It then waits for `ack` to rise, measures the run length, flags a timeout, and reports completion with a one-cycle pulse.
- Sits between the bench/host sequencer and the processor's start/ack pins; one instance per processor.

---
 rtl/run_pkg.sv | 25 ++
 rtl/run_launcher.sv | 139 +++++++++++++
 tb/tb_run_launcher.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/run_pkg.sv
// ============================================================================
// Module      : run_pkg
// Description : Shared types and default parameters for the run launcher.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package run_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } run_state_t;

    localparam int unsigned DEF_START_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT      = 4096;
    localparam int unsigned DEF_CNT_W        = 16;

    typedef logic [1:0] prog_id_t;

endpackage

`default_nettype wire

// File: rtl/run_launcher.sv
// ============================================================================
// Module      : run_launcher
// Description : Host-side start/ack run handshake initiator with run-length
//               measurement, timeout detection and a one-cycle done pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module run_launcher
    import run_pkg::*;
#(
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic [1:0]       prog_sel,
    input  logic             abort,
    output logic             run_ready,
    output logic             start,
    input  logic             ack,
    output logic [1:0]       prog_id,
    output logic             run_done,
    output logic             run_timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0]   START_LAST = SCW'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

    run_state_t       state_q, state_d;
    logic [SCW-1:0]   start_cnt_q, start_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    prog_id_t         prog_id_q, prog_id_d;
    logic             ack_q;
    logic             start_q, start_d;
    logic             run_ready_q, run_ready_d;
    logic             run_done_q, run_done_d;
    logic             run_timeout_q, run_timeout_d;
    logic             timeout_hit;
    logic             ack_rise;

    assign ack_rise = ack & ~ack_q;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            start_cnt_q   <= '0;
            cycle_cnt_q   <= '0;
            prog_id_q     <= '0;
            ack_q         <= 1'b0;
            start_q       <= 1'b0;
            run_ready_q   <= 1'b1;
            run_done_q    <= 1'b0;
            run_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
            prog_id_q     <= prog_id_d;
            ack_q         <= ack;
            start_q       <= start_d;
            run_ready_q   <= run_ready_d;
            run_done_q    <= run_done_d;
            run_timeout_q <= run_timeout_d;
        end
    end

    // Next-state and counter logic; abort overrides every transition
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        prog_id_d   = prog_id_q;
        timeout_hit = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_req) begin
                        prog_id_d   = prog_sel;
                        start_cnt_d = '0;
                        state_d     = START;
                    end
                end
                START: begin
                    if (start_cnt_q == START_LAST) begin
                        state_d     = WAIT;
                        cycle_cnt_d = '0;
                    end else begin
                        start_cnt_d = start_cnt_q + SCW'(1);
                    end
                end
                WAIT: begin
                    // A rise on the final allowed edge still counts as a completion.
                    if (ack_rise) begin
                        state_d = REPORT;
                    end else if (cycle_cnt_q == WAIT_LAST) begin
                        state_d     = REPORT;
                        cycle_cnt_d = WAIT_LIMIT;
                        timeout_hit = 1'b1;
                    end else begin
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        start_d       = (state_d == START);
        run_ready_d   = (state_d == IDLE);
        run_done_d    = (state_d == REPORT);
        run_timeout_d = timeout_hit;
    end

    assign run_ready   = run_ready_q;
    assign start       = start_q;
    assign prog_id     = prog_id_q;
    assign run_done    = run_done_q;
    assign run_timeout = run_timeout_q;
    assign cycle_count = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_run_launcher.sv
// ============================================================================
// Module      : tb_run_launcher
// Description : Self-checking bench for run_launcher against an ack-waveform
//               reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_run_launcher;

    localparam int SC = 2;
    localparam int TO = 4096;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run_req = 1'b0;
    logic [1:0]    prog_sel = 2'd0;
    logic          abort = 1'b0;
    logic          ack = 1'b0;
    logic          run_ready;
    logic          start;
    logic [1:0]    prog_id;
    logic          run_done;
    logic          run_timeout;
    logic [CW-1:0] cycle_count;

    int tests = 0;
    int fails = 0;

    run_launcher #(
        .START_CYCLES(SC),
        .TIMEOUT     (TO),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_req    (run_req),
        .prog_sel   (prog_sel),
        .abort      (abort),
        .run_ready  (run_ready),
        .start      (start),
        .ack        (ack),
        .prog_id    (prog_id),
        .run_done   (run_done),
        .run_timeout(run_timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ack level sampled at WAIT edge i: pre-launch level, low from fall, high from rise.
    function automatic logic ack_val(input logic pre, input int fall, input int rise, input int i);
        if (i >= rise) return 1'b1;
        if (i >= fall) return 1'b0;
        return pre;
    endfunction

    task automatic do_run(input logic [1:0] prog, input logic pre, input int fall,
                          input int rise, input int abort_at, input string name);
        bit   found;
        bit   tmo;
        bit   aborted;
        logic prev;
        logic a;
        int   k;
        int   end_e;
        int   exp_cnt;
        int   done_c;
        int   last_c;
        found = 1'b0;
        prev  = pre;
        k     = 0;
        for (int i = 0; i < TO; i++) begin
            a = ack_val(pre, fall, rise, i);
            if (!found && a && !prev) begin
                found = 1'b1;
                k     = i;
            end
            prev = a;
        end
        tmo     = !found;
        end_e   = found ? k : TO - 1;
        exp_cnt = found ? k : TO;
        aborted = (abort_at >= 0) && (abort_at <= end_e);
        if (aborted) exp_cnt = abort_at;
        done_c  = SC + 2 + end_e;
        last_c  = aborted ? SC + 2 + abort_at : done_c + 1;

        @(negedge clk);
        check($sformatf("%s ready_pre", name), 32'(run_ready), 32'd1);
        prog_sel = prog;
        ack      = pre;
        run_req  = 1'b1;
        abort    = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            check($sformatf("%s start c%0d", name, c), 32'(start), 32'(c <= SC));
            check($sformatf("%s done c%0d", name, c), 32'(run_done), 32'(!aborted && c == done_c));
            check($sformatf("%s tmo c%0d", name, c), 32'(run_timeout), 32'(!aborted && tmo && c == done_c));
            check($sformatf("%s ready c%0d", name, c), 32'(run_ready), 32'(c == last_c));
            if (c == last_c) begin
                check($sformatf("%s cycle_count", name), 32'(cycle_count), 32'(exp_cnt));
                check($sformatf("%s prog_id", name), 32'(prog_id), 32'(prog));
                run_req = 1'b0;
                abort   = 1'b0;
            end else begin
                run_req  = 1'($urandom);
                prog_sel = 2'($urandom);
                abort    = aborted && (c == SC + 1 + abort_at);
            end
            ack = (c <= SC) ? pre : ack_val(pre, fall, rise, c - SC - 1);
        end
    endtask

    initial begin
        int fall;
        int rise;
        int ab;
        repeat (2) @(negedge clk);
        check("rst ready", 32'(run_ready), 32'd1);
        check("rst start", 32'(start), 32'd0);
        check("rst done", 32'(run_done), 32'd0);
        check("rst tmo", 32'(run_timeout), 32'd0);
        check("rst prog_id", 32'(prog_id), 32'd0);
        check("rst count", 32'(cycle_count), 32'd0);
        reset = 1'b1;

        do_run(2'd2, 1'b0, 0, 7, -1, "normal");
        do_run(2'd1, 1'b1, 3, 5, -1, "stale");
        do_run(2'd3, 1'b0, 0, 100000, -1, "timeout");
        do_run(2'd0, 1'b0, 0, TO - 1, -1, "coincide");
        do_run(2'd1, 1'b0, 0, 20, 10, "abort");
        do_run(2'd2, 1'b0, 0, 3, -1, "after_abort");

        // abort together with run_req in IDLE must suppress the launch
        @(negedge clk);
        run_req  = 1'b1;
        abort    = 1'b1;
        prog_sel = 2'd3;
        @(negedge clk);
        run_req = 1'b0;
        abort   = 1'b0;
        @(negedge clk);
        check("idle_abort ready", 32'(run_ready), 32'd1);
        check("idle_abort start", 32'(start), 32'd0);
        check("idle_abort prog_id", 32'(prog_id), 32'd2);

        for (int n = 0; n < 10; n++) begin
            fall = int'($urandom_range(0, 4));
            rise = fall + int'($urandom_range(1, 40));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            do_run(2'($urandom), 1'($urandom), fall, rise, ab, $sformatf("rand%0d", n));
        end

        // asynchronous reset during START
        @(negedge clk);
        run_req  = 1'b1;
        prog_sel = 2'd3;
        ack      = 1'b0;
        @(negedge clk);
        run_req = 1'b0;
        check("mid_rst start_before", 32'(start), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst start", 32'(start), 32'd0);
        check("mid_rst ready", 32'(run_ready), 32'd1);
        check("mid_rst prog_id", 32'(prog_id), 32'd0);
        check("mid_rst count", 32'(cycle_count), 32'd0);
        check("mid_rst done", 32'(run_done), 32'd0);
        check("mid_rst tmo", 32'(run_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst start", 32'(start), 32'd0);
        check("post_rst ready", 32'(run_ready), 32'd1);
        check("post_rst done", 32'(run_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
